// File: rtl/debug_data_sender.sv
// Streams a debug snapshot (cycle count, PC, register file, data memory) out
// through a byte-wide UART transmitter, one 32-bit word at a time, MSB first.
module debug_data_sender #(
    parameter int UART_BITS        = 8,
    parameter int CLK_COUNTER_BITS = 32,
    parameter int PC_BITS          = 32,
    parameter int RF_REGS_LEN      = 1024,
    parameter int DATA_ADDRS_BITS  = 5,
    parameter int MEM_WORDS        = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_send_start,
    input  logic [CLK_COUNTER_BITS-1:0] i_clk_count,
    input  logic [PC_BITS-1:0]         i_pc,
    input  logic [RF_REGS_LEN-1:0]     i_rf_regs,
    input  logic [31:0]                i_mem_data,
    input  logic                       i_tx_done,
    output logic [DATA_ADDRS_BITS-1:0] o_mem_addr,
    output logic                       o_tx_start,
    output logic [UART_BITS-1:0]       o_tx_data,
    output logic                       o_send_done,
    output logic                       o_busy
);

    localparam int FIXED_WORDS = 34;
    localparam int WORDS       = FIXED_WORDS + MEM_WORDS;
    localparam int IDX_W       = $clog2(WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_WORD,
        MEM_WAIT,
        SEND_BYTE,
        WAIT_TX,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            wordIdx_q, wordIdx_d;
    logic [1:0]                  byteIdx_q, byteIdx_d;
    logic [31:0]                 word_q, word_d;
    logic [DATA_ADDRS_BITS-1:0]  memAddr_q, memAddr_d;
    logic [CLK_COUNTER_BITS-1:0] clkSnap_q, clkSnap_d;
    logic [PC_BITS-1:0]          pcSnap_q, pcSnap_d;
    logic [RF_REGS_LEN-1:0]      regsSnap_q, regsSnap_d;

    logic                        isMemWord;
    logic [4:0]                  regSel;
    logic [DATA_ADDRS_BITS-1:0]  memIdx;
    logic [31:0]                 snapWord;

    // Word index 0 and 1 are the scalar snapshots, 2..33 the registers, rest memory.
    always_comb begin
        isMemWord = (wordIdx_q >= IDX_W'(FIXED_WORDS));
        regSel    = 5'(int'(wordIdx_q) - 2);
        memIdx    = DATA_ADDRS_BITS'(int'(wordIdx_q) - FIXED_WORDS);
        if (wordIdx_q == IDX_W'(0)) begin
            snapWord = 32'(clkSnap_q);
        end else if (wordIdx_q == IDX_W'(1)) begin
            snapWord = 32'(pcSnap_q);
        end else begin
            snapWord = regsSnap_q[{regSel, 5'b00000} +: 32];
        end
    end

    always_comb begin
        state_d    = state_q;
        wordIdx_d  = wordIdx_q;
        byteIdx_d  = byteIdx_q;
        word_d     = word_q;
        memAddr_d  = memAddr_q;
        clkSnap_d  = clkSnap_q;
        pcSnap_d   = pcSnap_q;
        regsSnap_d = regsSnap_q;
        case (state_q)
            IDLE: begin
                if (i_send_start) begin
                    clkSnap_d  = i_clk_count;
                    pcSnap_d   = i_pc;
                    regsSnap_d = i_rf_regs;
                    wordIdx_d  = '0;
                    byteIdx_d  = '0;
                    state_d    = LOAD_WORD;
                end
            end
            LOAD_WORD: begin
                if (isMemWord) begin
                    memAddr_d = memIdx;
                    state_d   = MEM_WAIT;
                end else begin
                    word_d  = snapWord;
                    state_d = SEND_BYTE;
                end
            end
            MEM_WAIT: begin
                word_d  = i_mem_data;
                state_d = SEND_BYTE;
            end
            SEND_BYTE: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (byteIdx_q != 2'd3) begin
                        byteIdx_d = byteIdx_q + 2'd1;
                        state_d   = SEND_BYTE;
                    end else begin
                        byteIdx_d = '0;
                        if (wordIdx_q == IDX_W'(WORDS - 1)) begin
                            state_d = DONE;
                        end else begin
                            wordIdx_d = wordIdx_q + IDX_W'(1);
                            state_d   = LOAD_WORD;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wordIdx_q  <= '0;
            byteIdx_q  <= '0;
            word_q     <= '0;
            memAddr_q  <= '0;
            clkSnap_q  <= '0;
            pcSnap_q   <= '0;
            regsSnap_q <= '0;
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            byteIdx_q  <= byteIdx_d;
            word_q     <= word_d;
            memAddr_q  <= memAddr_d;
            clkSnap_q  <= clkSnap_d;
            pcSnap_q   <= pcSnap_d;
            regsSnap_q <= regsSnap_d;
        end
    end

    // The address is presented combinationally in LOAD_WORD so a synchronous RAM has data by MEM_WAIT.
    always_comb begin
        o_tx_start  = (state_q == SEND_BYTE);
        o_send_done = (state_q == DONE);
        o_busy      = (state_q != IDLE);
        o_mem_addr  = (state_q == LOAD_WORD && isMemWord) ? memIdx : memAddr_q;
        case (byteIdx_q)
            2'd0:    o_tx_data = UART_BITS'(word_q[31:24]);
            2'd1:    o_tx_data = UART_BITS'(word_q[23:16]);
            2'd2:    o_tx_data = UART_BITS'(word_q[15:8]);
            default: o_tx_data = UART_BITS'(word_q[7:0]);
        endcase
    end

endmodule

// File: tb/tb_debug_data_sender.sv
// Randomized self-checking bench for debug_data_sender: a UART responder and a
// synchronous RAM surround the DUT, and a queue-based dump model predicts every byte.
module tb_debug_data_sender;

    localparam int MEMW  = 2;
    localparam int WORDS = 34 + MEMW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_send_start;
    logic [31:0]   i_clk_count;
    logic [31:0]   i_pc;
    logic [1023:0] i_rf_regs;
    logic [31:0]   memData;
    logic          i_tx_done;
    logic [4:0]    o_mem_addr;
    logic          o_tx_start;
    logic [7:0]    o_tx_data;
    logic          o_send_done;
    logic          o_busy;

    logic [31:0]   memArray [32];
    logic [7:0]    rxBytes [$];
    int            doneCount = 0;
    bit            spuriousInSend = 1'b0;
    int            txDelay = 3;
    int            errors = 0;
    int            checks = 0;

    debug_data_sender #(
        .MEM_WORDS(MEMW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_send_start (i_send_start),
        .i_clk_count  (i_clk_count),
        .i_pc         (i_pc),
        .i_rf_regs    (i_rf_regs),
        .i_mem_data   (memData),
        .i_tx_done    (i_tx_done),
        .o_mem_addr   (o_mem_addr),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_send_done  (o_send_done),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory
    always @(posedge clk) memData <= memArray[o_mem_addr];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // UART transmitter stand-in: captures each launched byte and answers with a done pulse
    initial begin
        i_tx_done = 1'b0;
        @(negedge clk);
        forever begin
            if (o_tx_start) begin
                rxBytes.push_back(o_tx_data);
                if (spuriousInSend && (rxBytes.size() % 5 == 0)) begin
                    i_tx_done = 1'b1;
                    @(negedge clk);
                    i_tx_done = 1'b0;
                    repeat (txDelay - 1) @(negedge clk);
                end else begin
                    repeat (txDelay) @(negedge clk);
                end
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_send_done) doneCount++;
        end
    end

    task automatic applyStimulus(input bit directed, input bit secondStart, input bit spurious, input bit abortAt10);
        logic [31:0] words [$];
        logic [7:0]  expBytes [$];
        int          startDone;
        int          firstBad;
        int          n;
        if (directed) begin
            txDelay     = 3;
            i_clk_count = 32'h0000002A;
            i_pc        = 32'h00000010;
            for (int k = 0; k < 32; k++) i_rf_regs[k*32 +: 32] = k;
            memArray[0] = 32'hDEADBEEF;
            memArray[1] = 32'h01020304;
        end else begin
            txDelay     = $urandom_range(2, 5);
            i_clk_count = $urandom();
            i_pc        = $urandom();
            for (int k = 0; k < 32; k++) i_rf_regs[k*32 +: 32] = $urandom();
            for (int k = 0; k < 32; k++) memArray[k] = $urandom();
        end
        // Reference dump: fixed word order, each word split MSB first
        words.push_back(i_clk_count);
        words.push_back(i_pc);
        for (int k = 0; k < 32; k++) words.push_back(i_rf_regs[k*32 +: 32]);
        for (int k = 0; k < MEMW; k++) words.push_back(memArray[k]);
        foreach (words[w]) begin
            expBytes.push_back(words[w][31:24]);
            expBytes.push_back(words[w][23:16]);
            expBytes.push_back(words[w][15:8]);
            expBytes.push_back(words[w][7:0]);
        end

        rxBytes.delete();
        startDone      = doneCount;
        spuriousInSend = spurious;
        if (spurious) begin
            @(negedge clk);
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
        end

        @(negedge clk);
        i_send_start = 1'b1;
        @(negedge clk);
        i_send_start = 1'b0;
        checkOutput("busyAfterStart", o_busy, 1);
        checkOutput("noEarlyTxStart", o_tx_start, 0);
        // Inputs change after the accepting edge; the dump must not see this
        i_pc        = directed ? 32'hFFFFFFFF : $urandom();
        i_clk_count = $urandom();
        for (int k = 0; k < 32; k++) i_rf_regs[k*32 +: 32] = $urandom();
        @(negedge clk);
        checkOutput("txStartLatency", o_tx_start, 1);
        checkOutput("firstByte", o_tx_data, expBytes[0]);

        if (abortAt10) begin
            for (int c = 0; c < 2000 && rxBytes.size() < 10; c++) @(negedge clk);
            checkOutput("reachByte10", rxBytes.size() >= 10, 1);
            #2 rst = 1'b0;
            #1 checkOutput("abortOutputs", {o_tx_start, o_tx_data, o_send_done, o_busy, o_mem_addr}, 0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (10) @(negedge clk);
            checkOutput("noDoneAfterAbort", doneCount - startDone, 0);
            checkOutput("idleAfterAbort", o_busy, 0);
            spuriousInSend = 1'b0;
            return;
        end

        if (secondStart) begin
            repeat (30) @(negedge clk);
            i_send_start = 1'b1;
            @(negedge clk);
            i_send_start = 1'b0;
        end

        for (int c = 0; c < 20000 && doneCount == startDone; c++) @(negedge clk);
        checkOutput("doneSeen", doneCount != startDone, 1);
        repeat (10) @(negedge clk);
        checkOutput("doneCount", doneCount - startDone, 1);
        checkOutput("byteCount", rxBytes.size(), 4 * WORDS);
        firstBad = -1;
        for (int i = 0; i < expBytes.size(); i++) begin
            if (i >= rxBytes.size() || rxBytes[i] !== expBytes[i]) begin
                firstBad = i;
                break;
            end
        end
        checkOutput("firstBadByte", firstBad, 32'hFFFFFFFF);
        checkOutput("idleAfterDump", o_busy, 0);
        checkOutput("memAddrHold", o_mem_addr, MEMW - 1);
        n = rxBytes.size();
        if (directed && n >= 8) begin
            checkOutput("headWord", {rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3]}, 32'h0000002A);
            checkOutput("pcWord", {rxBytes[4], rxBytes[5], rxBytes[6], rxBytes[7]}, 32'h00000010);
            checkOutput("mem0Word", {rxBytes[n-8], rxBytes[n-7], rxBytes[n-6], rxBytes[n-5]}, 32'hDEADBEEF);
            checkOutput("mem1Word", {rxBytes[n-4], rxBytes[n-3], rxBytes[n-2], rxBytes[n-1]}, 32'h01020304);
        end
        spuriousInSend = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        i_send_start = 1'b0;
        i_clk_count  = '0;
        i_pc         = '0;
        i_rf_regs    = '0;
        for (int k = 0; k < 32; k++) memArray[k] = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", o_busy, 0);
        checkOutput("resetTxStart", o_tx_start, 0);
        checkOutput("resetTxData", o_tx_data, 0);
        checkOutput("resetSendDone", o_send_done, 0);
        checkOutput("resetMemAddr", o_mem_addr, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] directed dump");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        $display("[TB] spurious tx_done");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        $display("[TB] second start mid-dump");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        $display("[TB] reset after byte 10, then restart");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
